// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives instruction memory and
// registers the returned word into a valid-tagged IF/ID buffer.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        if_branch_taken,
  input  logic [15:0] if_branch_target,
  output logic [15:0] if_from_pc,
  input  logic [15:0] if_instruction,
  output logic [15:0] id_instruction,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus2,
  output logic        id_valid,
  output logic        if_halted,
  output logic [15:0] if_fetch_count
);

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] id_pc_q;
  logic [15:0] id_pc2_q;
  logic        valid_q;
  logic        halted_q;
  logic [15:0] cnt_q;
  logic [15:0] pc_plus2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Plain 16-bit add: FFFE wraps to 0000.
  assign pc_plus2 = pc_q + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      id_pc_q  <= 16'h0000;
      id_pc2_q <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 16'h0000;
    end else if (if_branch_taken) begin
      // Redirect wins over stall; id_pc/id_pc_plus2 keep their old values.
      state_q  <= S_FETCH;
      pc_q     <= {if_branch_target[15:1], 1'b0};
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (!if_stall) begin
      case (state_q)
        S_FETCH: begin
          instr_q  <= if_instruction;
          id_pc_q  <= pc_q;
          id_pc2_q <= pc_plus2;
          valid_q  <= 1'b1;
          cnt_q    <= sat_inc(cnt_q);
          if (if_instruction == HALT_WORD) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_plus2;
          end
        end
        default: begin
          instr_q <= 16'h0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_from_pc     = pc_q;
  assign id_instruction = instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus2    = id_pc2_q;
  assign id_valid       = valid_q;
  assign if_halted      = halted_q;
  assign if_fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed program walk plus randomized
// stall/branch/reset traffic compared every cycle against a behavioural model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall;
  logic        if_branch_taken;
  logic [15:0] if_branch_target;
  logic [15:0] if_from_pc;
  logic [15:0] if_instruction;
  logic [15:0] id_instruction;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus2;
  logic        id_valid;
  logic        if_halted;
  logic [15:0] if_fetch_count;

  logic [15:0] w_from_pc, w_instr, w_id_pc, w_id_pc2, w_cnt;
  logic        w_valid, w_halted;

  logic [15:0] mem [0:32767];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign if_instruction = mem[if_from_pc[15:1]];

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .if_stall(if_stall),
    .if_branch_taken(if_branch_taken), .if_branch_target(if_branch_target),
    .if_from_pc(if_from_pc), .if_instruction(if_instruction),
    .id_instruction(id_instruction), .id_pc(id_pc), .id_pc_plus2(id_pc_plus2),
    .id_valid(id_valid), .if_halted(if_halted), .if_fetch_count(if_fetch_count)
  );

  // Second instance exercises PC wrap from the top of the address space.
  instruction_fetch_unit #(.RESET_PC(16'hFFFE), .HALT_WORD(16'h0000)) u_wrap (
    .clk(clk), .rst(rst), .if_stall(1'b0),
    .if_branch_taken(1'b0), .if_branch_target(16'h0000),
    .if_from_pc(w_from_pc), .if_instruction(16'h1234),
    .id_instruction(w_instr), .id_pc(w_id_pc), .id_pc_plus2(w_id_pc2),
    .id_valid(w_valid), .if_halted(w_halted), .if_fetch_count(w_cnt)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one step per rising edge from the architectural rules.
  logic        m_known = 1'b0;
  logic [15:0] m_pc, m_instr, m_id_pc, m_id_pc2, m_cnt;
  logic        m_valid, m_halted;

  always @(posedge clk) begin
    logic [15:0] w;
    if (rst) begin
      m_known = 1'b1; m_pc = 16'h0000; m_instr = 16'h0000; m_id_pc = 16'h0000;
      m_id_pc2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0000;
    end else if (if_branch_taken) begin
      m_pc = if_branch_target & 16'hFFFE;
      m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (if_stall) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else begin
      w = mem[m_pc / 2];
      m_instr = w; m_id_pc = m_pc; m_id_pc2 = 16'((m_pc + 17'd2) % 17'h10000);
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (w == 16'h0000) m_halted = 1'b1;
      else m_pc = m_id_pc2;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("if_from_pc", if_from_pc, m_pc);
      check("id_instruction", id_instruction, m_instr);
      check("id_pc", id_pc, m_id_pc);
      check("id_pc_plus2", id_pc_plus2, m_id_pc2);
      check("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
      check("if_halted", {15'd0, if_halted}, {15'd0, m_halted});
      check("if_fetch_count", if_fetch_count, m_cnt);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] tgt;
    rst = 1'b1; if_stall = 1'b0; if_branch_taken = 1'b0; if_branch_target = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      tgt = 16'($urandom_range(1, 16'hFFFF));
      if (i >= 32 && $urandom_range(0, 15) == 0) tgt = 16'h0000;
      mem[i] = tgt;
    end
    mem[16'h0000 >> 1] = 16'hFE21; mem[16'h0002 >> 1] = 16'hFB22;
    mem[16'h0004 >> 1] = 16'h2388; mem[16'h0006 >> 1] = 16'h149A;
    mem[16'h0008 >> 1] = 16'hF564; mem[16'h000A >> 1] = 16'hF168;
    mem[16'h002C >> 1] = 16'hF111; mem[16'h0030 >> 1] = 16'hC890;
    mem[16'h003E >> 1] = 16'h0000;

    tick(2);
    check("rst pc", if_from_pc, 16'h0000);
    check("rst valid", {15'd0, id_valid}, 16'h0000);
    check("rst count", if_fetch_count, 16'h0000);
    check("wrap rst pc", w_from_pc, 16'hFFFE);
    rst = 1'b0;

    tick();
    check("first instr", id_instruction, 16'hFE21);
    check("first count", if_fetch_count, 16'h0001);
    check("next pc", if_from_pc, 16'h0002);
    check("wrap id_pc", w_id_pc, 16'hFFFE);
    check("wrap id_pc_plus2", w_id_pc2, 16'h0000);
    check("wrap pc", w_from_pc, 16'h0000);
    tick();
    check("second instr", id_instruction, 16'hFB22);
    tick();
    check("third instr", id_instruction, 16'h2388);
    check("third id_pc", id_pc, 16'h0004);
    check("third count", if_fetch_count, 16'h0003);
    tick();
    check("pre-stall pc", if_from_pc, 16'h0008);

    if_stall = 1'b1;
    tick(3);
    check("stall pc", if_from_pc, 16'h0008);
    check("stall instr", id_instruction, 16'h149A);
    check("stall count", if_fetch_count, 16'h0004);
    if_stall = 1'b0;
    tick();
    check("release instr", id_instruction, 16'hF564);
    tick();
    check("release instr2", id_instruction, 16'hF168);

    tick(12);
    check("branch src pc", if_from_pc, 16'h0024);
    if_branch_taken = 1'b1; if_branch_target = 16'h002C;
    tick();
    if_branch_taken = 1'b0; if_branch_target = 16'h5555;
    check("branch pc", if_from_pc, 16'h002C);
    check("branch bubble", {15'd0, id_valid}, 16'h0000);
    tick();
    check("target instr", id_instruction, 16'hF111);
    check("target id_pc", id_pc, 16'h002C);

    if_branch_taken = 1'b1; if_branch_target = 16'h002D; if_stall = 1'b1;
    tick();
    if_branch_taken = 1'b0; if_stall = 1'b0;
    check("odd target pc", if_from_pc, 16'h002C);
    tick();
    check("odd target instr", id_instruction, 16'hF111);

    tick(8);
    check("halt pc", if_from_pc, 16'h003E);
    tick();
    check("halt word", id_instruction, 16'h0000);
    check("halt valid", {15'd0, id_valid}, 16'h0001);
    check("halted", {15'd0, if_halted}, 16'h0001);
    tick(2);
    check("halt hold pc", if_from_pc, 16'h003E);
    check("halt bubble", {15'd0, id_valid}, 16'h0000);

    if_branch_taken = 1'b1; if_branch_target = 16'h0030;
    tick();
    if_branch_taken = 1'b0;
    check("unhalt", {15'd0, if_halted}, 16'h0000);
    tick();
    check("unhalt instr", id_instruction, 16'hC890);

    if_stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; if_stall = 1'b0;
    check("mid rst pc", if_from_pc, 16'h0000);
    check("mid rst instr", id_instruction, 16'h0000);
    check("mid rst count", if_fetch_count, 16'h0000);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if_stall = ($urandom_range(0, 3) == 0);
      if_branch_taken = ($urandom_range(0, 11) == 0);
      if_branch_target = 16'($urandom);
      tick();
    end
    rst = 1'b0; if_stall = 1'b0; if_branch_taken = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the pipeline that drives the instruction memory. Holds the program counter, presents it to `instruction_memory` each cycle, and registers the returned 16-bit instruction into the IF/ID buffer. Handles stall, branch redirect/flush, and HALT detection so the rest of the pipeline sees a clean, valid-tagged instruction stream.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HALT_WORD`, 16'h0000, instruction encoding that stops fetch.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_stall`  in  1  hazard unit hold; freezes PC and IF/ID.
- `if_branch_taken`  in  1  resolved taken branch from later stage; one-cycle pulse.
- `if_branch_target`  in  16  redirect address; valid when `if_branch_taken`=1.
- `if_from_pc`  out  16  current PC to instruction memory (registered).
- `if_instruction`  in  16  instruction memory read data for `if_from_pc` (combinational, same cycle).
- `id_instruction`  out  16  IF/ID buffered instruction.
- `id_pc`  out  16  address of `id_instruction`.
- `id_pc_plus2`  out  16  `id_pc`+2, for branch/link arithmetic downstream.
- `id_valid`  out  1  1 = `id_instruction` is real; 0 = bubble.
- `if_halted`  out  1  fetch stopped on HALT_WORD.
- `if_fetch_count`  out  16  count of instructions delivered with `id_valid`=1; saturates at 16'hFFFF.

## Operation
- States: FETCH, HALT. Reset -> FETCH.
- Reset values: PC=`RESET_PC`, `id_instruction`=0, `id_pc`=0, `id_pc_plus2`=0, `id_valid`=0, `if_halted`=0, `if_fetch_count`=0, state FETCH.
- Per-cycle priority (highest first): `rst` > `if_branch_taken` > `if_stall` > normal fetch.
- Branch taken (any state): PC <= {`if_branch_target`[15:1],1'b0} (bit 0 forced 0); IF/ID loaded with bubble (`id_instruction`=0, `id_valid`=0, `id_pc`/`id_pc_plus2` unchanged); state -> FETCH; `if_halted` <= 0. Overrides a simultaneous stall.
- Stall (no branch): PC, IF/ID, state, counter all hold.
- FETCH, normal: IF/ID <= {`if_instruction`, PC, PC+2}, `id_valid` <= 1, counter increments (saturating).
  - If `if_instruction` != `HALT_WORD`: PC <= PC+2 (16-bit wrap: 16'hFFFE -> 16'h0000).
  - If `if_instruction` == `HALT_WORD`: PC holds, state -> HALT, `if_halted` <= 1. HALT word itself is delivered once with `id_valid`=1.
- HALT, normal: PC holds; IF/ID loaded with bubble each cycle; counter holds. Leaves only via branch or reset.
- Bubble encoding is 16'h0000 with `id_valid`=0; downstream must qualify on `id_valid`, not on the word.

## Timing
- `if_from_pc` is a register output; instruction memory is combinational, so fetch-to-IF/ID latency is 1 cycle: PC presented in cycle N appears on `id_*` after edge N+1.
- Branch penalty: pulse in cycle N -> `if_from_pc`=target in N+1, bubble on `id_*` in N+1, target instruction on `id_*` in N+2.
- Reset deasserted in cycle N -> `if_from_pc`=`RESET_PC` in N, first valid `id_*` after edge N+1.
- Reset mid-operation (including during HALT or stall): all state returns to reset values at next edge; no partial update.
- `if_halted` rises the same edge the HALT word enters IF/ID; falls the edge a branch redirect or reset is taken.
- `if_branch_target` sampled only when `if_branch_taken`=1; ignored otherwise.

## Test plan
- Reset then run, no stall: `if_from_pc` 0000, 0002, 0004...; `id_instruction` FE21 (id_pc 0000), FB22 (0002), 2388 (0004); `if_fetch_count` 1,2,3.
- Stall at `if_from_pc`=0008 for 3 cycles: PC stays 0008, `id_instruction` stays 149A, count frozen; release -> F564 then F168.
- Branch pulse target 002C while PC=0024: next `if_from_pc`=002C, `id_valid`=0 for one cycle, then F111 with id_pc 002C; odd target 002D also yields 002C. Branch with simultaneous `if_stall`=1: branch wins.
- Run to 003E: `id_instruction`=0000, `id_valid`=1 once, `if_halted`=1, PC holds 003E, subsequent `id_valid`=0, count holds at value including HALT.
- In HALT, branch pulse target 0030: `if_halted`=0, next valid `id_instruction`=C890; separately, `rst` asserted mid-stall -> all outputs to reset values next edge.
- PC wrap: `RESET_PC`=16'hFFFE, memory returns non-halt word -> PC goes FFFE -> 0000, `id_pc_plus2`=0000 for the FFFE fetch.
